apb_mux_tmo: RTL and testbench
==============================

APB_MUX_TMO -- requirements
Module: apb_mux_tmo

Interface
REQ-001 Parameter PADDR_SIZE, default 12, sets the address width.
REQ-002 Parameter PDATA_SIZE, default 32, sets the data width.
REQ-003 Parameter SLAVES, default 4, range 1..16, sets the slave port count.
REQ-004 Parameter TIMEOUT, default 255, is the maximum number of wait-state cycles; 0 disables the timeout.
REQ-005 PCLK  in  1  sole clock; all state updates on the rising edge.
REQ-006 PRESETn  in  1  synchronous, active-low reset, sampled on the PCLK rising edge.
REQ-007 MST_PSEL, MST_PENABLE, MST_PWRITE  in  1 each  master APB controls.
REQ-008 MST_PADDR  in  PADDR_SIZE  master address.
REQ-009 MST_PWDATA  in  PDATA_SIZE  master write data.
REQ-010 MST_PRDATA  out  PDATA_SIZE  read data returned to the master.
REQ-011 MST_PREADY, MST_PSLVERR  out  1 each  master completion and error.
REQ-012 slv_addr[SLAVES], slv_mask[SLAVES]  in  PADDR_SIZE each  per-slave base address and compare mask.
REQ-013 SLV_PSEL[SLAVES]  out  1 each  one-hot slave select.
REQ-014 SLV_PENABLE, SLV_PWRITE  out  1 each  shared; broadcast to all slaves.
REQ-015 SLV_PADDR  out  PADDR_SIZE  shared; broadcast to all slaves.
REQ-016 SLV_PWDATA  out  PDATA_SIZE  shared; broadcast to all slaves.
REQ-017 SLV_PRDATA[SLAVES]  in  PDATA_SIZE each  slave read data.
REQ-018 SLV_PREADY[SLAVES], SLV_PSLVERR[SLAVES]  in  1 each  slave responses.
REQ-019 tmo_o  out  1  one-cycle pulse on each timeout completion.
REQ-020 err_cnt_o  out  8  saturating count of decode misses plus timeouts.

Function
REQ-021 Decode: slave s matches when (MST_PADDR & slv_mask[s]) == (slv_addr[s] & slv_mask[s]).
REQ-022 Overlapping matches: the lowest-index match wins, so at most one SLV_PSEL is ever high.
REQ-023 FSM states are IDLE and ACCESS.
REQ-024 IDLE to ACCESS: on a cycle with MST_PSEL=1 and MST_PENABLE=0 (setup phase).
REQ-025 Setup-phase outputs: SLV_PSEL of the winner is asserted combinationally in that same cycle.
REQ-026 At the end of the setup cycle, the winner index and a hit flag are registered.
REQ-027 In ACCESS, SLV_PSEL is driven from the registered index only; MST_PADDR changes do not re-decode.
REQ-028 SLV_PADDR, SLV_PWDATA, SLV_PWRITE and SLV_PENABLE follow the master combinationally.
REQ-029 SLV_PENABLE is forced to 0 when no slave is selected.
REQ-030 Hit, ACCESS: MST_PRDATA, MST_PREADY and MST_PSLVERR equal the selected slave's signals.
REQ-031 Miss, ACCESS: the first access cycle returns MST_PREADY=1, MST_PSLVERR=1 and MST_PRDATA=0; no SLV_PSEL is asserted.
REQ-032 ACCESS to IDLE: on MST_PREADY=1, or when MST_PSEL=0 (master abort, no error counted).
REQ-033 Back-to-back transfers: a setup phase in the cycle after completion re-enters ACCESS.
REQ-034 Wait counter: 8 bits wide; cleared on entry to ACCESS.
REQ-035 Wait counter: increments each ACCESS cycle in which the selected slave's PREADY=0.
REQ-036 Timeout: when TIMEOUT != 0 and the wait counter equals TIMEOUT, the mux returns MST_PREADY=1, MST_PSLVERR=1, MST_PRDATA=0.
REQ-037 Timeout: in that same cycle SLV_PSEL is deasserted, tmo_o=1, and the FSM returns to IDLE.
REQ-038 Simultaneous slave PREADY=1 and counter==TIMEOUT: the slave response wins; no timeout.
REQ-039 err_cnt_o increments by 1 per miss or timeout completion.
REQ-040 err_cnt_o holds at 255 once reached.
REQ-041 When MST_PREADY=0, MST_PRDATA and MST_PSLVERR are 0.

Reset
REQ-042 While PRESETn=0 at a PCLK edge: FSM -> IDLE; wait counter, registered index and hit flag, tmo_o and err_cnt_o -> 0.
REQ-043 During reset: all SLV_PSEL=0, SLV_PENABLE=0, MST_PREADY=0, MST_PSLVERR=0, MST_PRDATA=0.
REQ-044 Reset asserted mid-transfer abandons the transfer; no error is counted.
REQ-045 After reset, the first setup phase is decoded normally.

Verification
REQ-046 Read hit: SLAVES=4, slave2 addr=0x200, mask=0xF00; read 0x234; slave2 returns 0xCAFEF00D after 3 wait cycles -> SLV_PSEL[2] for 5 cycles, MST_PRDATA=0xCAFEF00D, PSLVERR=0.
REQ-047 Miss: access 0xF00 with no match -> MST_PREADY=1 and PSLVERR=1 on the first access cycle, PRDATA=0, err_cnt_o=1.
REQ-048 Overlap: slave1 and slave3 both match 0x100 -> only SLV_PSEL[1] is asserted.
REQ-049 Timeout: TIMEOUT=4, slave holds PREADY=0 -> completion with PSLVERR=1 on the 5th access cycle; tmo_o pulses once.
REQ-050 Timeout boundary: slave raises PREADY in the same cycle the counter reaches 4 -> normal completion, tmo_o=0.
REQ-051 Reset and saturation: 260 misses -> err_cnt_o=255; PRESETn low for one cycle -> err_cnt_o=0; next hit transfer succeeds.

Source files
------------

// File: rtl/apb_mux_tmo.sv
// APB 1-to-N slave multiplexer with mask/base address decode, wait-state
// timeout, and a saturating error counter for decode misses and timeouts.
module apb_mux_tmo #(
  parameter int PADDR_SIZE = 12,
  parameter int PDATA_SIZE = 32,
  parameter int SLAVES     = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  MST_PSEL,
  input  logic                  MST_PENABLE,
  input  logic                  MST_PWRITE,
  input  logic [PADDR_SIZE-1:0] MST_PADDR,
  input  logic [PDATA_SIZE-1:0] MST_PWDATA,
  output logic [PDATA_SIZE-1:0] MST_PRDATA,
  output logic                  MST_PREADY,
  output logic                  MST_PSLVERR,
  input  logic [PADDR_SIZE-1:0] slv_addr [SLAVES],
  input  logic [PADDR_SIZE-1:0] slv_mask [SLAVES],
  output logic [SLAVES-1:0]     SLV_PSEL,
  output logic                  SLV_PENABLE,
  output logic                  SLV_PWRITE,
  output logic [PADDR_SIZE-1:0] SLV_PADDR,
  output logic [PDATA_SIZE-1:0] SLV_PWDATA,
  input  logic [PDATA_SIZE-1:0] SLV_PRDATA [SLAVES],
  input  logic [SLAVES-1:0]     SLV_PREADY,
  input  logic [SLAVES-1:0]     SLV_PSLVERR,
  output logic                  tmo_o,
  output logic [7:0]            err_cnt_o
);

  localparam int IDX_W = (SLAVES > 1) ? $clog2(SLAVES) : 1;
  localparam logic [7:0] TMO_VAL = 8'(TIMEOUT);
  localparam logic TMO_EN = (TIMEOUT != 0);

  typedef enum logic {IDLE, ACCESS} state_e;

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d, win_idx;
  logic                   hit_q, hit_d, win_hit;
  logic [7:0]             wait_q, wait_d;
  logic [7:0]             err_q, err_d;

  logic                   setup, act, tmo;
  logic                   slv_rdy, slv_err;
  logic [PDATA_SIZE-1:0]  slv_rd;
  logic [SLAVES-1:0]      sel;
  logic                   pready, pslverr;
  logic [PDATA_SIZE-1:0]  prdata;

  // Scan from the top down so the lowest-index match is the one left standing.
  always_comb begin
    win_idx = '0;
    win_hit = 1'b0;
    for (int s = SLAVES - 1; s >= 0; s--) begin
      if ((MST_PADDR & slv_mask[s]) == (slv_addr[s] & slv_mask[s])) begin
        win_idx = IDX_W'(s);
        win_hit = 1'b1;
      end
    end
  end

  always_comb begin
    slv_rdy = SLV_PREADY[idx_q];
    slv_err = SLV_PSLVERR[idx_q];
    slv_rd  = SLV_PRDATA[idx_q];
    setup   = (state_q == IDLE) && MST_PSEL && !MST_PENABLE;
    act     = (state_q == ACCESS) && MST_PSEL;
    tmo     = act && hit_q && !slv_rdy && TMO_EN && (wait_q == TMO_VAL);
  end

  always_comb begin
    sel     = '0;
    pready  = 1'b0;
    pslverr = 1'b0;
    prdata  = '0;
    if (setup && win_hit) begin
      sel[win_idx] = 1'b1;
    end else if (act && hit_q && !tmo) begin
      sel[idx_q] = 1'b1;
    end
    if (act) begin
      if (!hit_q || tmo) begin
        pready  = 1'b1;
        pslverr = 1'b1;
      end else if (slv_rdy) begin
        pready  = 1'b1;
        pslverr = slv_err;
        prdata  = slv_rd;
      end
    end
    // Reset is synchronous, so outputs are masked until the state settles.
    if (!PRESETn) begin
      sel     = '0;
      pready  = 1'b0;
      pslverr = 1'b0;
      prdata  = '0;
    end
  end

  assign SLV_PSEL    = sel;
  assign SLV_PENABLE = MST_PENABLE && (|sel);
  assign SLV_PWRITE  = MST_PWRITE;
  assign SLV_PADDR   = MST_PADDR;
  assign SLV_PWDATA  = MST_PWDATA;
  assign MST_PREADY  = pready;
  assign MST_PSLVERR = pslverr;
  assign MST_PRDATA  = prdata;
  assign tmo_o       = tmo && PRESETn;
  assign err_cnt_o   = err_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    hit_d   = hit_q;
    wait_d  = wait_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (setup) begin
          state_d = ACCESS;
          idx_d   = win_idx;
          hit_d   = win_hit;
          wait_d  = '0;
        end
      end
      ACCESS: begin
        if (!MST_PSEL || pready) begin
          state_d = IDLE;
        end else if (!slv_rdy && (wait_q != 8'hFF)) begin
          wait_d = wait_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (((act && !hit_q) || tmo) && (err_q != 8'hFF)) begin
      err_d = err_q + 8'd1;
    end
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_q <= IDLE;
      idx_q   <= '0;
      hit_q   <= 1'b0;
      wait_q  <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hit_q   <= hit_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_apb_mux_tmo.sv
// Directed bench for apb_mux_tmo (TIMEOUT=4): expected {PRDATA,PSLVERR} per
// transfer is queued at setup and compared when the mux completes.
module tb_apb_mux_tmo;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic        MST_PSEL, MST_PENABLE, MST_PWRITE;
  logic [11:0] MST_PADDR;
  logic [31:0] MST_PWDATA;
  logic [31:0] MST_PRDATA;
  logic        MST_PREADY, MST_PSLVERR;
  logic [11:0] slv_addr [4];
  logic [11:0] slv_mask [4];
  logic [3:0]  SLV_PSEL;
  logic        SLV_PENABLE, SLV_PWRITE;
  logic [11:0] SLV_PADDR;
  logic [31:0] SLV_PWDATA;
  logic [31:0] SLV_PRDATA [4];
  logic [3:0]  rdy_vec, err_vec;
  logic        tmo_o;
  logic [7:0]  err_cnt_o;

  int total = 0;
  int bad   = 0;
  logic [32:0] exp_q [$];
  int   r_acc, r_sel, r_pen, r_tmo;
  logic [3:0] r_or;

  always #5 PCLK = ~PCLK;

  apb_mux_tmo #(.PADDR_SIZE(12), .PDATA_SIZE(32), .SLAVES(4), .TIMEOUT(4)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .MST_PSEL(MST_PSEL), .MST_PENABLE(MST_PENABLE), .MST_PWRITE(MST_PWRITE),
    .MST_PADDR(MST_PADDR), .MST_PWDATA(MST_PWDATA),
    .MST_PRDATA(MST_PRDATA), .MST_PREADY(MST_PREADY), .MST_PSLVERR(MST_PSLVERR),
    .slv_addr(slv_addr), .slv_mask(slv_mask),
    .SLV_PSEL(SLV_PSEL), .SLV_PENABLE(SLV_PENABLE), .SLV_PWRITE(SLV_PWRITE),
    .SLV_PADDR(SLV_PADDR), .SLV_PWDATA(SLV_PWDATA),
    .SLV_PRDATA(SLV_PRDATA), .SLV_PREADY(rdy_vec), .SLV_PSLVERR(err_vec),
    .tmo_o(tmo_o), .err_cnt_o(err_cnt_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drives one transfer; rdy_at = wait cycles before slaves raise PREADY (-1 = never).
  task automatic apb(input logic [11:0] a, input logic w, input int rdy_at, input logic [32:0] exp);
    logic done;
    exp_q.push_back(exp);
    MST_PSEL = 1'b1; MST_PENABLE = 1'b0; MST_PADDR = a; MST_PWRITE = w;
    MST_PWDATA = {20'h0, a}; rdy_vec = 4'h0;
    r_acc = 0; r_sel = 0; r_pen = 0; r_tmo = 0; r_or = 4'h0;
    @(negedge PCLK);
    if (SLV_PSEL != 4'h0) r_sel++;
    r_or |= SLV_PSEL;
    r_tmo += int'(tmo_o);
    @(posedge PCLK); #1;
    MST_PENABLE = 1'b1;
    MST_PADDR = 12'hF00;
    done = 1'b0;
    while (!done && r_acc < 50) begin
      r_acc++;
      rdy_vec = (rdy_at >= 0 && r_acc > rdy_at) ? 4'hF : 4'h0;
      @(negedge PCLK);
      if (SLV_PSEL != 4'h0) r_sel++;
      r_or |= SLV_PSEL;
      r_pen += int'(SLV_PENABLE);
      r_tmo += int'(tmo_o);
      done = MST_PREADY;
      @(posedge PCLK); #1;
    end
    MST_PSEL = 1'b0; MST_PENABLE = 1'b0; rdy_vec = 4'h0;
    chk("xfer_completes", 32'(done), 32'd1);
  endtask

  initial begin
    logic [32:0] e;
    forever begin
      @(negedge PCLK);
      total++;
      if (MST_PREADY) begin
        assert (exp_q.size() != 0) else begin
          bad++;
          $error("FAIL unexpected_completion observed=%0h expected=no_completion", {MST_PRDATA, MST_PSLVERR});
        end
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          total++;
          assert ({MST_PRDATA, MST_PSLVERR} === e) else begin
            bad++;
            $error("FAIL response observed=%0h expected=%0h", {MST_PRDATA, MST_PSLVERR}, e);
          end
        end
      end else begin
        assert ({MST_PRDATA, MST_PSLVERR} === 33'h0) else begin
          bad++;
          $error("FAIL idle_response observed=%0h expected=0", {MST_PRDATA, MST_PSLVERR});
        end
      end
    end
  end

  initial begin
    slv_addr   = '{12'h000, 12'h100, 12'h200, 12'h130};
    slv_mask   = '{12'hF00, 12'hF00, 12'hF00, 12'hF0F};
    SLV_PRDATA = '{32'h1111_0000, 32'h1111_0001, 32'hCAFE_F00D, 32'h1111_0003};
    rdy_vec = 4'h0; err_vec = 4'h0;
    PRESETn = 1'b0;
    MST_PSEL = 1'b1; MST_PENABLE = 1'b0; MST_PADDR = 12'h234; MST_PWRITE = 1'b0; MST_PWDATA = '0;
    repeat (2) @(posedge PCLK);
    @(negedge PCLK);
    chk("rst_psel", 32'(SLV_PSEL), 32'h0);
    chk("rst_penable", 32'(SLV_PENABLE), 32'h0);
    chk("rst_pready", 32'(MST_PREADY), 32'h0);
    chk("rst_errcnt", 32'(err_cnt_o), 32'h0);
    chk("rst_tmo", 32'(tmo_o), 32'h0);
    @(posedge PCLK); #1;
    PRESETn = 1'b1; MST_PSEL = 1'b0;
    @(posedge PCLK); #1;

    apb(12'h234, 1'b0, 3, {32'hCAFE_F00D, 1'b0});
    chk("hit_acc", 32'(r_acc), 32'd4);
    chk("hit_selcyc", 32'(r_sel), 32'd5);
    chk("hit_sel", 32'(r_or), 32'h4);
    chk("hit_pen", 32'(r_pen), 32'd4);
    chk("hit_tmo", 32'(r_tmo), 32'd0);

    apb(12'h010, 1'b1, 0, {32'h1111_0000, 1'b0});
    chk("wr_sel", 32'(r_or), 32'h1);
    chk("wr_acc", 32'(r_acc), 32'd1);

    apb(12'hF00, 1'b0, 0, {32'h0, 1'b1});
    chk("miss_acc", 32'(r_acc), 32'd1);
    chk("miss_selcyc", 32'(r_sel), 32'd0);
    chk("miss_pen", 32'(r_pen), 32'd0);
    chk("miss_errcnt", 32'(err_cnt_o), 32'd1);

    apb(12'h100, 1'b0, 1, {32'h1111_0001, 1'b0});
    chk("ovl_sel", 32'(r_or), 32'h2);
    chk("ovl_selcyc", 32'(r_sel), 32'd3);
    chk("ovl_acc", 32'(r_acc), 32'd2);

    apb(12'h200, 1'b0, -1, {32'h0, 1'b1});
    chk("tmo_acc", 32'(r_acc), 32'd5);
    chk("tmo_selcyc", 32'(r_sel), 32'd5);
    chk("tmo_pen", 32'(r_pen), 32'd4);
    chk("tmo_pulses", 32'(r_tmo), 32'd1);
    chk("tmo_errcnt", 32'(err_cnt_o), 32'd2);

    apb(12'h200, 1'b0, 4, {32'hCAFE_F00D, 1'b0});
    chk("bnd_acc", 32'(r_acc), 32'd5);
    chk("bnd_selcyc", 32'(r_sel), 32'd6);
    chk("bnd_tmo", 32'(r_tmo), 32'd0);
    chk("bnd_errcnt", 32'(err_cnt_o), 32'd2);

    err_vec = 4'h4;
    apb(12'h2FC, 1'b0, 0, {32'hCAFE_F00D, 1'b1});
    err_vec = 4'h0;
    chk("slverr_errcnt", 32'(err_cnt_o), 32'd2);

    apb(12'hF00, 1'b0, 0, {32'h0, 1'b1});
    apb(12'h1A0, 1'b0, 2, {32'h1111_0001, 1'b0});
    chk("b2b_acc", 32'(r_acc), 32'd3);
    chk("b2b_sel", 32'(r_or), 32'h2);
    chk("b2b_errcnt", 32'(err_cnt_o), 32'd3);

    MST_PSEL = 1'b1; MST_PENABLE = 1'b0; MST_PADDR = 12'h200; rdy_vec = 4'h0;
    @(posedge PCLK); #1;
    MST_PENABLE = 1'b1;
    @(posedge PCLK); #1;
    MST_PSEL = 1'b0; MST_PENABLE = 1'b0;
    @(negedge PCLK);
    chk("abort_psel", 32'(SLV_PSEL), 32'h0);
    @(posedge PCLK); #1;
    chk("abort_errcnt", 32'(err_cnt_o), 32'd3);
    apb(12'h0F0, 1'b0, 1, {32'h1111_0000, 1'b0});
    chk("post_abort_sel", 32'(r_or), 32'h1);
    chk("post_abort_acc", 32'(r_acc), 32'd2);

    for (int i = 0; i < 260; i++) apb(12'hF00, 1'b0, 0, {32'h0, 1'b1});
    chk("sat_errcnt", 32'(err_cnt_o), 32'd255);

    MST_PSEL = 1'b1; MST_PENABLE = 1'b0; MST_PADDR = 12'h234; rdy_vec = 4'h0;
    @(posedge PCLK); #1;
    MST_PENABLE = 1'b1;
    @(posedge PCLK); #1;
    PRESETn = 1'b0;
    @(negedge PCLK);
    chk("midrst_psel", 32'(SLV_PSEL), 32'h0);
    chk("midrst_pready", 32'(MST_PREADY), 32'h0);
    chk("midrst_penable", 32'(SLV_PENABLE), 32'h0);
    @(posedge PCLK); #1;
    PRESETn = 1'b1; MST_PSEL = 1'b0; MST_PENABLE = 1'b0;
    chk("midrst_errcnt", 32'(err_cnt_o), 32'd0);
    @(posedge PCLK); #1;

    apb(12'h234, 1'b0, 2, {32'hCAFE_F00D, 1'b0});
    chk("after_rst_acc", 32'(r_acc), 32'd3);
    chk("after_rst_sel", 32'(r_or), 32'h4);
    chk("after_rst_errcnt", 32'(err_cnt_o), 32'd0);

    @(negedge PCLK);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
